bp_update_scheduler: RTL and testbench

- Serialises branch-resolution updates from the two EX slots of the 2-way core into the local predictor's single update port (Branch_EX, branchTaken, branch_target_EX, nextPC, LHR/LHPT/BTB indices).
- Buffers up to DEPTH resolved branches in program order, with slot 0 older than slot 1, and issues at most one update per cycle.
- Stalls EX when the buffer cannot take two more entries.
- Discards a slot-1 branch that is younger than a mispredicted slot-0 branch.

---
 rtl/bp_pkg.sv | 19 +
 rtl/bp_upd_fifo.sv | 36 +++
 rtl/bp_update_scheduler.sv | 82 ++++++++
 tb/tb_bp_update_scheduler.sv | 127 ++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared widths, update-entry type and pack/unpack helpers for the branch update scheduler
package bp_pkg;
  localparam int IDX_W = 4;
  localparam int ENTRY_W = 1 + 32 + 32 + 3 * IDX_W;
  typedef struct packed {
    logic             taken;
    logic [31:0]      target;
    logic [31:0]      nextpc;
    logic [IDX_W-1:0] lhr_idx;
    logic [IDX_W-1:0] lhpt_idx;
    logic [IDX_W-1:0] btb_idx;
  } upd_entry_t;
  function automatic logic [ENTRY_W-1:0] pack_entry(input upd_entry_t e);
    return e;
  endfunction
  function automatic upd_entry_t unpack_entry(input logic [ENTRY_W-1:0] b);
    return b;
  endfunction
endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: dual-write (wa then wb), single-read circular FIFO; ports clk/Reset, wa_*/wb_* writes, rd_en pop, rd_data head, count occupancy
module bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W = 77
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             wa_en,
  input  logic [W-1:0]     wa_data,
  input  logic             wb_en,
  input  logic [W-1:0]     wb_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic [PTR_W:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp, rp;
  assign rd_data = mem[rp];
  always_ff @(posedge clk) begin
    if (wa_en) mem[wp] <= wa_data;
    if (wb_en) mem[wp + PTR_W'(1)] <= wb_data;
  end
  // pointers wrap naturally at DEPTH; full vs empty comes from count
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + PTR_W'(wa_en) + PTR_W'(wb_en);
      rp <= rp + PTR_W'(rd_en);
      count <= count + (PTR_W+1)'(wa_en) + (PTR_W+1)'(wb_en) - (PTR_W+1)'(rd_en);
    end
  end
endmodule

// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: serialises two EX-slot branch resolutions into one predictor update port; ports ex0_*/ex1_* in, upd_hold in, upd_* out, stall_ex, pending
module bp_update_scheduler
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int IDX_W = bp_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             ex0_valid,
  input  logic             ex0_taken,
  input  logic             ex0_mispredict,
  input  logic [31:0]      ex0_target,
  input  logic [31:0]      ex0_nextpc,
  input  logic [IDX_W-1:0] ex0_lhr_idx,
  input  logic [IDX_W-1:0] ex0_lhpt_idx,
  input  logic [IDX_W-1:0] ex0_btb_idx,
  input  logic             ex1_valid,
  input  logic             ex1_taken,
  input  logic [31:0]      ex1_target,
  input  logic [31:0]      ex1_nextpc,
  input  logic [IDX_W-1:0] ex1_lhr_idx,
  input  logic [IDX_W-1:0] ex1_lhpt_idx,
  input  logic [IDX_W-1:0] ex1_btb_idx,
  input  logic             upd_hold,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic [31:0]      upd_target,
  output logic [31:0]      upd_nextpc,
  output logic [IDX_W-1:0] upd_lhr_idx,
  output logic [IDX_W-1:0] upd_lhpt_idx,
  output logic [IDX_W-1:0] upd_btb_idx,
  output logic             stall_ex,
  output logic [PTR_W:0]   pending
);
  upd_entry_t e0, e1, head;
  logic [ENTRY_W-1:0] head_bits;
  logic eff1, acc0, acc1, pop;
  assign e0 = {ex0_taken, ex0_target, ex0_nextpc, ex0_lhr_idx, ex0_lhpt_idx, ex0_btb_idx};
  assign e1 = {ex1_taken, ex1_target, ex1_nextpc, ex1_lhr_idx, ex1_lhpt_idx, ex1_btb_idx};
  // pre-pop occupancy: conservative, but guarantees room for two writes
  assign stall_ex = pending > (PTR_W+1)'(DEPTH - 2);
  // a slot-1 branch behind a mispredicted slot-0 branch is on the wrong path
  assign eff1 = ex1_valid && !(ex0_valid && ex0_mispredict);
  assign acc0 = !stall_ex && ex0_valid;
  assign acc1 = !stall_ex && eff1;
  assign pop = !upd_hold && pending != '0;
  assign head = unpack_entry(head_bits);
  bp_upd_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(ENTRY_W)) u_fifo (
    .clk    (clk),
    .Reset  (Reset),
    .wa_en  (acc0 || acc1),
    .wa_data(pack_entry(acc0 ? e0 : e1)),
    .wb_en  (acc0 && acc1),
    .wb_data(pack_entry(e1)),
    .rd_en  (pop),
    .rd_data(head_bits),
    .count  (pending)
  );
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      upd_valid <= 1'b0;
      upd_taken <= 1'b0;
      upd_target <= '0;
      upd_nextpc <= '0;
      upd_lhr_idx <= '0;
      upd_lhpt_idx <= '0;
      upd_btb_idx <= '0;
    end else begin
      upd_valid <= pop;
      if (pop) begin
        upd_taken <= head.taken;
        upd_target <= head.target;
        upd_nextpc <= head.nextpc;
        upd_lhr_idx <= head.lhr_idx;
        upd_lhpt_idx <= head.lhpt_idx;
        upd_btb_idx <= head.btb_idx;
      end
    end
  end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb_bp_update_scheduler: table-driven vectors with a scoreboard queue for bp_update_scheduler
module tb_bp_update_scheduler;
  import bp_pkg::*;
  logic clk = 1'b0, Reset = 1'b1;
  logic ex0_valid = 0, ex0_taken = 0, ex0_mispredict = 0;
  logic [31:0] ex0_target = 0, ex0_nextpc = 0;
  logic [3:0] ex0_lhr_idx = 0, ex0_lhpt_idx = 0, ex0_btb_idx = 0;
  logic ex1_valid = 0, ex1_taken = 0;
  logic [31:0] ex1_target = 0, ex1_nextpc = 0;
  logic [3:0] ex1_lhr_idx = 0, ex1_lhpt_idx = 0, ex1_btb_idx = 0;
  logic upd_hold = 0;
  logic upd_valid, upd_taken, stall_ex;
  logic [31:0] upd_target, upd_nextpc;
  logic [3:0] upd_lhr_idx, upd_lhpt_idx, upd_btb_idx;
  logic [2:0] pending;
  bp_update_scheduler dut (
    .clk(clk), .Reset(Reset),
    .ex0_valid(ex0_valid), .ex0_taken(ex0_taken), .ex0_mispredict(ex0_mispredict),
    .ex0_target(ex0_target), .ex0_nextpc(ex0_nextpc),
    .ex0_lhr_idx(ex0_lhr_idx), .ex0_lhpt_idx(ex0_lhpt_idx), .ex0_btb_idx(ex0_btb_idx),
    .ex1_valid(ex1_valid), .ex1_taken(ex1_taken),
    .ex1_target(ex1_target), .ex1_nextpc(ex1_nextpc),
    .ex1_lhr_idx(ex1_lhr_idx), .ex1_lhpt_idx(ex1_lhpt_idx), .ex1_btb_idx(ex1_btb_idx),
    .upd_hold(upd_hold),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_target(upd_target), .upd_nextpc(upd_nextpc),
    .upd_lhr_idx(upd_lhr_idx), .upd_lhpt_idx(upd_lhpt_idx), .upd_btb_idx(upd_btb_idx),
    .stall_ex(stall_ex), .pending(pending)
  );
  always #5 clk = ~clk;
  typedef struct {
    int v0, t0, m0, tg0, lhpt0, btb0, v1, t1, lhpt1, hold, pend, stall;
  } vec_t;
  vec_t tbl[$];
  upd_entry_t sb[$];
  int model_pend = 0, seq = 0, n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [76:0] act, input logic [76:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask
  function automatic logic [76:0] out_bits();
    return {upd_taken, upd_target, upd_nextpc, upd_lhr_idx, upd_lhpt_idx, upd_btb_idx};
  endfunction
  task automatic cycle(input vec_t v, input string tag);
    upd_entry_t e0, e1, exp_e;
    int acc;
    bit exp_v;
    seq++;
    ex0_valid = 1'(v.v0); ex0_taken = 1'(v.t0); ex0_mispredict = 1'(v.m0);
    ex0_target = 32'(v.tg0); ex0_nextpc = 32'h8000_0000 + 32'(seq);
    ex0_lhr_idx = 4'(seq); ex0_lhpt_idx = 4'(v.lhpt0); ex0_btb_idx = 4'(v.btb0);
    ex1_valid = 1'(v.v1); ex1_taken = 1'(v.t1);
    ex1_target = 32'(v.tg0) + 32'h100; ex1_nextpc = 32'h9000_0000 + 32'(seq);
    ex1_lhr_idx = 4'(seq + 1); ex1_lhpt_idx = 4'(v.lhpt1); ex1_btb_idx = 4'(v.btb0 + 1);
    upd_hold = 1'(v.hold);
    e0 = '{ex0_taken, ex0_target, ex0_nextpc, ex0_lhr_idx, ex0_lhpt_idx, ex0_btb_idx};
    e1 = '{ex1_taken, ex1_target, ex1_nextpc, ex1_lhr_idx, ex1_lhpt_idx, ex1_btb_idx};
    acc = 0;
    exp_e = '0;
    exp_v = v.hold == 0 && model_pend > 0;
    if (exp_v) exp_e = sb.pop_front();
    if (4 - model_pend >= 2) begin
      if (v.v0 != 0) begin sb.push_back(e0); acc++; end
      if (v.v1 != 0 && !(v.v0 != 0 && v.m0 != 0)) begin sb.push_back(e1); acc++; end
    end
    model_pend = model_pend + acc - int'(exp_v);
    @(posedge clk); #1;
    chk({tag, " upd_valid"}, 77'(upd_valid), 77'(exp_v));
    if (exp_v) chk({tag, " entry"}, out_bits(), exp_e);
    chk({tag, " pending"}, 77'(pending), 77'(v.pend));
    chk({tag, " stall_ex"}, 77'(stall_ex), 77'(v.stall));
  endtask
  initial begin
    vec_t idle0, idle1, idle2;
    idle0 = '{0,0,0,0,0,0,0,0,0,0,0,0};
    idle1 = '{0,0,0,0,0,0,0,0,0,0,1,0};
    idle2 = '{0,0,0,0,0,0,0,0,0,0,2,0};
    tbl.push_back('{1,1,0,'h00400040,0,3,0,0,0,0,1,0});
    tbl.push_back(idle0);
    tbl.push_back(idle0);
    tbl.push_back('{1,0,0,'h00400100,5,1,1,1,9,0,2,0});
    tbl.push_back(idle1);
    tbl.push_back(idle0);
    tbl.push_back(idle0);
    tbl.push_back('{1,1,1,'h00400200,2,2,1,0,7,0,1,0});
    tbl.push_back(idle0);
    tbl.push_back(idle0);
    tbl.push_back('{1,1,0,'h00401000,1,4,1,0,2,1,2,0});
    tbl.push_back('{1,0,0,'h00401100,3,5,1,1,4,1,4,1});
    tbl.push_back('{1,1,0,'h00401200,6,6,1,1,7,1,4,1});
    tbl.push_back('{1,1,0,'h00401300,8,7,1,1,9,0,3,1});
    tbl.push_back(idle2);
    tbl.push_back(idle1);
    tbl.push_back(idle0);
    tbl.push_back(idle0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset upd_valid", 77'(upd_valid), 77'(0));
    chk("reset outputs", out_bits(), 77'(0));
    chk("reset pending", 77'(pending), 77'(0));
    chk("reset stall_ex", 77'(stall_ex), 77'(0));
    Reset = 1'b0;
    foreach (tbl[i]) cycle(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 20; i++)
      cycle('{1, i & 1, 0, 'h00500000 + i * 16, i & 15, (i + 3) & 15, 0, 0, 0, 0, 1, 0}, $sformatf("steady%0d", i));
    cycle(idle0, "steady_drain");
    cycle(idle0, "steady_idle");
    cycle('{1,1,0,'h00600000,1,1,1,0,2,0,2,0}, "rst_fill0");
    cycle('{1,0,0,'h00600100,3,3,1,1,4,0,3,1}, "rst_fill1");
    ex0_valid = 0; ex1_valid = 0;
    #3 Reset = 1'b1;
    #1;
    chk("midrst upd_valid", 77'(upd_valid), 77'(0));
    chk("midrst pending", 77'(pending), 77'(0));
    chk("midrst stall_ex", 77'(stall_ex), 77'(0));
    sb.delete();
    model_pend = 0;
    @(posedge clk); #1;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle(idle0, $sformatf("post_rst%0d", i));
    cycle('{1,0,0,'h00700000,7,9,0,0,0,0,1,0}, "post_rst_acc");
    cycle(idle0, "post_rst_pop");
    cycle(idle0, "post_rst_idle");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
